fpadd_sched: RTL
================

FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one adder.
REQ-002 The block SHALL have parameter WFP, default 32: operand and result width in bits.
REQ-003 The block SHALL have parameter LAT, default 3: fixed adder latency in cycles from issue to result, LAT >= 1.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: scheduler enable.
REQ-007 The block SHALL have port req_valid, input, NREQ bits: per-requester operation pending.
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-hot grant; a request is accepted when valid and ready are both high.
REQ-009 The block SHALL have port req_a, input, NREQ*WFP bits: operand A, requester i in slice [i*WFP +: WFP].
REQ-010 The block SHALL have port req_b, input, NREQ*WFP bits: operand B, same slicing as req_a.
REQ-011 The block SHALL have port req_rmode, input, NREQ*2 bits: rounding mode per requester; 00 nearest-even, 01 zero, 10 +inf, 11 -inf.
REQ-012 The block SHALL have port add_issue, output, 1 bit: operation launched into the adder this cycle.
REQ-013 The block SHALL have port add_a, output, WFP bits: operand A to the adder.
REQ-014 The block SHALL have port add_b, output, WFP bits: operand B to the adder.
REQ-015 The block SHALL have port add_rmode, output, 2 bits: rounding mode to the adder.
REQ-016 The block SHALL have port add_res, input, WFP bits: adder result, valid exactly LAT cycles after add_issue.
REQ-017 The block SHALL have port rsp_valid, output, NREQ bits: one-hot result strobe to the originating requester.
REQ-018 The block SHALL have port rsp_data, output, WFP bits: result data, meaningful only while rsp_valid is nonzero.
REQ-019 The block SHALL have port busy, output, 1 bit: high when any operation is in flight.
REQ-020 The block SHALL have port idle, output, 1 bit: high in state IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and DRAIN; IDLE to RUN when en=1; RUN to DRAIN when en=0; DRAIN to IDLE when no operation is in flight; DRAIN to RUN when en=1 again.
REQ-022 In RUN only, the arbiter SHALL grant one valid requester per cycle, round-robin, searching upward (with wrap) from the requester after the last one granted; after reset the search SHALL start at requester 0.
REQ-023 req_ready SHALL be combinational from req_valid and the round-robin pointer, SHALL be all-zero outside RUN, and SHALL have at most one bit high.
REQ-024 On an accepted request, add_a, add_b and add_rmode SHALL be registered from the granted slices, and add_issue SHALL go high on the following cycle for exactly one cycle; add_* SHALL hold their last values when add_issue is low.
REQ-025 An issued operation SHALL produce its result to the adder LAT cycles after add_issue; the arbiter SHALL be able to accept one request per cycle (full throughput, no bubbles).
REQ-026 A tag pipeline of length LAT SHALL carry the one-hot requester ID alongside each issue; when the tag emerges, rsp_valid SHALL equal it for one cycle and rsp_data SHALL equal add_res sampled that cycle.
REQ-027 Result ordering SHALL be issue order; requester-side latency SHALL be LAT+2 cycles from acceptance to rsp_valid.
REQ-028 Responses SHALL not back-pressure; requesters SHALL accept rsp_valid unconditionally.
REQ-029 busy SHALL be high whenever the accept register or any tag-pipeline stage holds an operation.
REQ-030 On the same-cycle event of en falling and a valid request, the request SHALL not be accepted; operations already in flight SHALL complete normally in DRAIN.
REQ-031 The round-robin pointer SHALL advance only on acceptance and SHALL wrap from NREQ-1 to 0.

Reset
REQ-032 While resetn=0, the FSM SHALL be IDLE, the pointer SHALL be 0, and all tag stages SHALL be cleared.
REQ-033 While resetn=0, req_ready, add_issue, rsp_valid and busy SHALL be 0, idle SHALL be 1, and add_a, add_b, add_rmode and rsp_data SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard in-flight tags, so that no rsp_valid is produced after reset is released.

Verification
REQ-035 Single request: en=1; requester 2 presents a=0x3F800000, b=0x40000000, rmode=00 -> add_issue one cycle after acceptance; rsp_valid=4'b0100 with rsp_data=model add_res LAT+2 cycles after acceptance.
REQ-036 All four requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; one issue per cycle; responses in the same order.
REQ-037 Requester 1 mid-stream with rmode=11, others 00 -> add_rmode=11 only on the cycle requester 1's operation issues.
REQ-038 en dropped while 3 operations are in flight -> no new grants; 3 rsp_valid pulses; busy falls; idle=1 after the last response.
REQ-039 resetn pulsed low with 2 operations in flight -> outputs take their reset values immediately (asynchronously); no rsp_valid after release; first grant afterwards goes to requester 0.
REQ-040 Simultaneous en fall and req_valid=4'b1111 -> req_ready=0 that cycle; FSM enters DRAIN.

Source files
------------

// File: rtl/fpadd_sched.sv
// fpadd_sched: round-robin scheduler sharing one fixed-latency FP adder among NREQ requesters.
// Requests are registered into the adder; a one-hot tag pipeline routes each result back.
module fpadd_sched #(
   parameter int NREQ = 4,
   parameter int WFP  = 32,
   parameter int LAT  = 3
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                en,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*WFP-1:0] req_a,
   input  logic [NREQ*WFP-1:0] req_b,
   input  logic [NREQ*2-1:0]   req_rmode,
   output logic                add_issue,
   output logic [WFP-1:0]      add_a,
   output logic [WFP-1:0]      add_b,
   output logic [1:0]          add_rmode,
   input  logic [WFP-1:0]      add_res,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [WFP-1:0]      rsp_data,
   output logic                busy,
   output logic                idle
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, gidx, cand;
   logic [NREQ-1:0] id_q, rsp_valid_q, tags_or;
   logic [NREQ-1:0] tag_q [LAT];
   logic [WFP-1:0] a_q, b_q, rsp_data_q;
   logic [1:0] rmode_q;
   logic issue_q, found, accept;
   // first valid requester at or above the pointer, wrapping
   always_comb begin
      gidx = ptr_q;
      cand = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(ptr_q) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gidx = cand;
         end
      end
      accept = found && state_q == RUN && en;
      req_ready = '0;
      req_ready[gidx] = accept;
      ptr_d = accept ? (gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
   end
   always_comb begin
      tags_or = '0;
      for (int i = 0; i < LAT; i++) tags_or = tags_or | tag_q[i];
      busy = issue_q || |tags_or;
      idle = state_q == IDLE;
      state_d = state_q == RUN ? (en ? RUN : DRAIN)
              : en ? RUN
              : (state_q == DRAIN && busy) ? DRAIN : IDLE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         ptr_q <= '0;
         issue_q <= 1'b0;
         id_q <= '0;
         a_q <= '0;
         b_q <= '0;
         rmode_q <= '0;
         rsp_valid_q <= '0;
         rsp_data_q <= '0;
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         issue_q <= accept;
         id_q <= req_ready;
         if (accept) begin
            a_q <= req_a[gidx*WFP +: WFP];
            b_q <= req_b[gidx*WFP +: WFP];
            rmode_q <= req_rmode[gidx*2 +: 2];
         end
         // id_q is zero on non-issue cycles, so empty stages carry no tag
         tag_q[0] <= id_q;
         for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
         rsp_valid_q <= tag_q[LAT-1];
         if (|tag_q[LAT-1]) rsp_data_q <= add_res;
      end
   end
   assign add_issue = issue_q;
   assign add_a = a_q;
   assign add_b = b_q;
   assign add_rmode = rmode_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data = rsp_data_q;
endmodule
